// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: word width, FSM states and requester indices.
// Optional alignment checking is enabled by defining DMEM_ALIGN_CHECK_EN.
package dmem_pkg;

    localparam int WORD_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_AUX = 1'b1;

endpackage

// File: rtl/datamem_arbiter_if.sv
// Requester handshakes plus the shared memory port of the data-memory arbiter.
// err0/err1 exist only when DMEM_ALIGN_CHECK_EN is defined.
interface datamem_arbiter_if #(
    parameter int WORD_WIDTH = dmem_pkg::WORD_WIDTH
);
    logic                  req0;
    logic                  req1;
    logic [WORD_WIDTH-1:0] addr0;
    logic [WORD_WIDTH-1:0] addr1;
    logic                  wr0;
    logic                  wr1;
    logic [WORD_WIDTH-1:0] wdata0;
    logic [WORD_WIDTH-1:0] wdata1;
    logic                  ack0;
    logic                  ack1;
    logic [WORD_WIDTH-1:0] rdata0;
    logic [WORD_WIDTH-1:0] rdata1;
    logic [WORD_WIDTH-1:0] mem_addr;
    logic                  mem_wr;
    logic [WORD_WIDTH-1:0] mem_wdata;
    logic [WORD_WIDTH-1:0] mem_rdata;
`ifdef DMEM_ALIGN_CHECK_EN
    logic                  err0;
    logic                  err1;
`endif

    // Arbiter side
    modport slave (
        input  req0, req1, addr0, addr1, wr0, wr1, wdata0, wdata1, mem_rdata,
        output ack0, ack1, rdata0, rdata1, mem_addr, mem_wr, mem_wdata
`ifdef DMEM_ALIGN_CHECK_EN
        , output err0, err1
`endif
    );

    // Requesters and memory side
    modport master (
        output req0, req1, addr0, addr1, wr0, wr1, wdata0, wdata1, mem_rdata,
        input  ack0, ack1, rdata0, rdata1, mem_addr, mem_wr, mem_wdata
`ifdef DMEM_ALIGN_CHECK_EN
        , input err0, err1
`endif
    );

endinterface

// File: rtl/datamem_arbiter_rr_pick2.sv
// Combinational two-way round-robin winner select; prio names the favoured requester on a tie.
module rr_pick2 (
    input  logic i_req0,
    input  logic i_req1,
    input  logic i_prio,
    output logic o_valid,
    output logic o_winner
);
    assign o_valid  = i_req0 | i_req1;
    assign o_winner = (i_req0 & i_req1) ? i_prio : i_req1;
endmodule

// File: rtl/datamem_arbiter.sv
// Round-robin arbiter giving two requesters one-cycle access to the shared data memory.
// Define DMEM_ALIGN_CHECK_EN to block misaligned writes and report them on err0/err1.
module datamem_arbiter #(
    parameter int WORD_WIDTH = dmem_pkg::WORD_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    datamem_arbiter_if.slave bus
);
    import dmem_pkg::*;

    state_t                r_state;
    logic                  r_owner;
    logic                  r_prio;
    logic [WORD_WIDTH-1:0] r_rdata;

    logic                  w_pick_valid;
    logic                  w_pick_winner;
    logic                  w_access;
    logic                  w_resp;
    logic                  w_other_req;
    logic                  w_misaligned;
    logic [WORD_WIDTH-1:0] w_sel_addr;
    logic [WORD_WIDTH-1:0] w_sel_wdata;
    logic                  w_sel_wr;

    rr_pick2 u_pick (
        .i_req0  (bus.req0),
        .i_req1  (bus.req1),
        .i_prio  (r_prio),
        .o_valid (w_pick_valid),
        .o_winner(w_pick_winner)
    );

    assign w_access    = (r_state == ST_ACCESS);
    assign w_resp      = (r_state == ST_RESP);
    assign w_sel_addr  = (r_owner == REQ_AUX) ? bus.addr1  : bus.addr0;
    assign w_sel_wdata = (r_owner == REQ_AUX) ? bus.wdata1 : bus.wdata0;
    assign w_sel_wr    = (r_owner == REQ_AUX) ? bus.wr1    : bus.wr0;
    assign w_other_req = (r_owner == REQ_AUX) ? bus.req0   : bus.req1;

`ifdef DMEM_ALIGN_CHECK_EN
    logic r_err;
    assign w_misaligned = |w_sel_addr[1:0];
    assign bus.err0     = bus.ack0 & r_err;
    assign bus.err1     = bus.ack1 & r_err;
`else
    assign w_misaligned = 1'b0;
`endif

    // Memory port is live only in ACCESS, so a reset in that cycle still lets the write land.
    assign bus.mem_addr  = w_access ? w_sel_addr  : '0;
    assign bus.mem_wdata = w_access ? w_sel_wdata : '0;
    assign bus.mem_wr    = w_access & w_sel_wr & ~w_misaligned;

    assign bus.ack0   = w_resp & (r_owner == REQ_CPU);
    assign bus.ack1   = w_resp & (r_owner == REQ_AUX);
    assign bus.rdata0 = bus.ack0 ? r_rdata : '0;
    assign bus.rdata1 = bus.ack1 ? r_rdata : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_owner <= REQ_CPU;
            r_prio  <= REQ_CPU;
            r_rdata <= '0;
`ifdef DMEM_ALIGN_CHECK_EN
            r_err   <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pick_valid) begin
                        r_owner <= w_pick_winner;
                        r_state <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    r_rdata <= bus.mem_rdata;
                    r_prio  <= ~r_owner;
`ifdef DMEM_ALIGN_CHECK_EN
                    r_err   <= w_misaligned;
`endif
                    r_state <= ST_RESP;
                end
                ST_RESP: begin
                    // Owner's own req is ignored here; only a waiting peer keeps the bus busy.
                    if (w_other_req) begin
                        r_owner <= ~r_owner;
                        r_state <= ST_ACCESS;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_datamem_arbiter.sv
// Directed bench for datamem_arbiter with a big-endian byte memory model behind the shared port.
// Alignment checks run only when DMEM_ALIGN_CHECK_EN is defined.
module tb_datamem_arbiter;

    typedef struct {
        bit          r0, r1, w0, w1;
        logic [31:0] a0, a1, d0, d1;
        int          lat0, lat1;     // cycles from request to ack, 0 = no ack expected
        logic [31:0] e0, e1;         // expected read words (ignored for writes)
        int          nwr;            // expected memory write strobes
        bit          er0, er1;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic load_mem;
    int   n_checks = 0;
    int   n_err = 0;

    datamem_arbiter_if bus ();

    datamem_arbiter dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [0:255];
    logic [7:0] ma;
    assign ma = bus.mem_addr[7:0];
    assign bus.mem_rdata = {mem[ma], mem[ma + 8'd1], mem[ma + 8'd2], mem[ma + 8'd3]};

    always @(posedge clk) begin
        if (load_mem) begin
            for (int i = 0; i < 256; i++) mem[i] <= i[7:0];
        end else if (bus.mem_wr) begin
            mem[ma]        <= bus.mem_wdata[31:24];
            mem[ma + 8'd1] <= bus.mem_wdata[23:16];
            mem[ma + 8'd2] <= bus.mem_wdata[15:8];
            mem[ma + 8'd3] <= bus.mem_wdata[7:0];
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    // Called on a negedge right after requests were applied; drops each req once acked.
    task automatic wait_acks(input string name, input vec_t v);
        int got0 = 0, got1 = 0, wrs = 0, gate = 0;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            @(posedge clk);
            @(negedge clk);
            wrs += int'(bus.mem_wr);
            if (!bus.ack0 && bus.rdata0 != 32'h0) gate++;
            if (!bus.ack1 && bus.rdata1 != 32'h0) gate++;
            if (bus.ack0) begin
                check({name, ".lat0"}, cyc, v.lat0);
                if (!v.w0) check({name, ".rdata0"}, bus.rdata0, v.e0);
`ifdef DMEM_ALIGN_CHECK_EN
                check({name, ".err0"}, {31'h0, bus.err0}, {31'h0, v.er0});
`endif
                bus.req0 = 1'b0;
                got0 = cyc;
            end
            if (bus.ack1) begin
                check({name, ".lat1"}, cyc, v.lat1);
                if (!v.w1) check({name, ".rdata1"}, bus.rdata1, v.e1);
`ifdef DMEM_ALIGN_CHECK_EN
                check({name, ".err1"}, {31'h0, bus.err1}, {31'h0, v.er1});
`endif
                bus.req1 = 1'b0;
                got1 = cyc;
            end
            if ((v.lat0 == 0 || got0 != 0) && (v.lat1 == 0 || got1 != 0)) break;
        end
        check({name, ".ack0_seen"}, {31'h0, got0 != 0}, {31'h0, v.lat0 != 0});
        check({name, ".ack1_seen"}, {31'h0, got1 != 0}, {31'h0, v.lat1 != 0});
        check({name, ".writes"}, wrs, v.nwr);
        check({name, ".rdata_gate"}, gate, 0);
        $display("txn %s: ack0@%0d ack1@%0d writes=%0d", name, got0, got1, wrs);
    endtask

    task automatic apply(input string name, input vec_t v);
        @(negedge clk);
        bus.req0 = v.r0; bus.wr0 = v.w0; bus.addr0 = v.a0; bus.wdata0 = v.d0;
        bus.req1 = v.r1; bus.wr1 = v.w1; bus.addr1 = v.a1; bus.wdata1 = v.d1;
        wait_acks(name, v);
    endtask

    vec_t vecs[8];
    vec_t hv;

    initial begin
        // fields: r0 r1 w0 w1 a0 a1 d0 d1 lat0 lat1 e0 e1 nwr er0 er1
        vecs[0] = '{1,0,1,0, 32'h10, 32'h0,  32'hDEADBEEF, 32'h0,        2,0, 32'h0,        32'h0,        1, 0,0};
        vecs[1] = '{1,0,0,0, 32'h10, 32'h0,  32'h0,        32'h0,        2,0, 32'hDEADBEEF, 32'h0,        0, 0,0};
        vecs[2] = '{1,1,0,1, 32'h20, 32'h20, 32'h0,        32'h12345678, 4,2, 32'h12345678, 32'h0,        1, 0,0};
        vecs[3] = '{1,1,0,0, 32'h20, 32'h10, 32'h0,        32'h0,        4,2, 32'h12345678, 32'hDEADBEEF, 0, 0,0};
        vecs[4] = '{0,1,0,0, 32'h0,  32'h44, 32'h0,        32'h0,        0,2, 32'h0,        32'h44454647, 0, 0,0};
        vecs[5] = '{1,1,1,1, 32'h30, 32'h34, 32'hA5A5A5A5, 32'h0F0F0F0F, 2,4, 32'h0,        32'h0,        2, 0,0};
        vecs[6] = '{1,1,0,0, 32'h30, 32'h34, 32'h0,        32'h0,        2,4, 32'hA5A5A5A5, 32'h0F0F0F0F, 0, 0,0};
        vecs[7] = '{1,0,0,0, 32'h31, 32'h0,  32'h0,        32'h0,        2,0, 32'hA5A5A50F, 32'h0,        0, 1,0};

        // Reset held two cycles with both requesters already asking
        rst = 1'b1; load_mem = 1'b1;
        bus.req0 = 1'b1; bus.wr0 = 1'b0; bus.addr0 = 32'h40; bus.wdata0 = 32'h0;
        bus.req1 = 1'b1; bus.wr1 = 1'b0; bus.addr1 = 32'h44; bus.wdata1 = 32'h0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            load_mem = 1'b0;
            check($sformatf("reset%0d.ack", c), {30'h0, bus.ack1, bus.ack0}, 32'h0);
            check($sformatf("reset%0d.mem_wr", c), {31'h0, bus.mem_wr}, 32'h0);
            check($sformatf("reset%0d.mem_addr", c), bus.mem_addr, 32'h0);
            check($sformatf("reset%0d.rdata", c), bus.rdata0 | bus.rdata1, 32'h0);
        end
        rst = 1'b0;
        hv = '{1,1,0,0, 32'h40, 32'h44, 32'h0, 32'h0, 2,4, 32'h40414243, 32'h44454647, 0, 0,0};
        wait_acks("reset_contend", hv);

        for (int i = 0; i < 8; i++) apply($sformatf("vec%0d", i), vecs[i]);

        // Both held continuously: prio is 1 here, so acks go 1,0,1,0,1 every two cycles
        begin
            int n0 = 0, n1 = 0;
            logic [1:0] exp;
            @(negedge clk);
            bus.req0 = 1'b1; bus.wr0 = 1'b0; bus.addr0 = 32'h10;
            bus.req1 = 1'b1; bus.wr1 = 1'b0; bus.addr1 = 32'h20;
            for (int cyc = 1; cyc <= 12; cyc++) begin
                @(posedge clk);
                @(negedge clk);
                exp = {(cyc == 2 || cyc == 6 || cyc == 10), (cyc == 4 || cyc == 8)};
                check($sformatf("sustain.c%0d", cyc), {30'h0, bus.ack1, bus.ack0}, {30'h0, exp});
                if (bus.ack0) begin n0++; if (n0 == 2) bus.req0 = 1'b0; end
                if (bus.ack1) begin n1++; if (n1 == 3) bus.req1 = 1'b0; end
            end
            $display("txn sustain: acks0=%0d acks1=%0d", n0, n1);
        end

        // Reset during ACCESS of a req1 write: write still strobes, no ack, reissue completes
        @(negedge clk);
        bus.req1 = 1'b1; bus.wr1 = 1'b1; bus.addr1 = 32'h50; bus.wdata1 = 32'hCAFEF00D;
        @(posedge clk);
        @(negedge clk);
        check("midrst.mem_wr", {31'h0, bus.mem_wr}, 32'h1);
        check("midrst.mem_addr", bus.mem_addr, 32'h50);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrst.no_ack", {30'h0, bus.ack1, bus.ack0}, 32'h0);
        check("midrst.idle_addr", bus.mem_addr, 32'h0);
        rst = 1'b0;
        hv = '{0,1,0,1, 32'h0, 32'h50, 32'h0, 32'hCAFEF00D, 0,2, 32'h0, 32'h0, 1, 0,0};
        wait_acks("midrst_reissue", hv);
        hv = '{1,0,0,0, 32'h50, 32'h0, 32'h0, 32'h0, 2,0, 32'hCAFEF00D, 32'h0, 0, 0,0};
        apply("midrst_readback", hv);

`ifdef DMEM_ALIGN_CHECK_EN
        hv = '{1,0,1,0, 32'h13, 32'h0, 32'hFFFFFFFF, 32'h0, 2,0, 32'h0, 32'h0, 0, 1,0};
        apply("align_wr", hv);
        hv = '{1,0,0,0, 32'h10, 32'h0, 32'h0, 32'h0, 2,0, 32'hDEADBEEF, 32'h0, 0, 0,0};
        apply("align_rb0", hv);
        hv = '{0,1,0,0, 32'h0, 32'h14, 32'h0, 32'h0, 0,2, 32'h0, 32'h14151617, 0, 0,0};
        apply("align_rb1", hv);
`endif

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/datamem_arbiter.md
# datamem_arbiter

Two-requester arbiter sharing the single byte-addressed, big-endian data memory (combinational read, write on clock edge) between the processor data port (requester 0) and the bench/loader or DMA port (requester 1). Each requester uses a req/ack handshake. The arbiter selects a winner round-robin, drives the memory port for exactly one cycle, registers the read word, and returns it with a one-cycle ack pulse. It sits between the requesters and `datamem`, and owns that memory's `data_addr`, `data_wr` and `data_in` lines.

## Interface
- `WORD_WIDTH`, 32, data word and address width.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req0`, `req1`  in  1  request from requester 0 / 1; held high with stable fields until ack.
- `addr0`, `addr1`  in  WORD_WIDTH  byte address of the word access.
- `wr0`, `wr1`  in  1  1 = write, 0 = read.
- `wdata0`, `wdata1`  in  WORD_WIDTH  write data.
- `ack0`, `ack1`  out  1  one-cycle completion pulse.
- `rdata0`, `rdata1`  out  WORD_WIDTH  read word, valid while the matching ack is high.
- `mem_addr`  out  WORD_WIDTH  to `datamem` `data_addr`.
- `mem_wr`  out  1  to `datamem` `data_wr`.
- `mem_wdata`  out  WORD_WIDTH  to `datamem` `data_in`.
- `mem_rdata`  in  WORD_WIDTH  from `datamem` `data_out`.
- `err0`, `err1`  out  1  misalignment flag, valid with ack; present only with `DMEM_ALIGN_CHECK_EN`.

## Operation
- FSM states are IDLE, ACCESS and RESP. The registers are `owner` (1 bit), `prio` (1 bit, favoured requester), `rdata_q` and `err_q`.
- IDLE:
  - If no req, stay in IDLE.
  - If exactly one req, set `owner` to that requester and go to ACCESS.
  - If both req, set `owner = prio` and go to ACCESS.
- ACCESS:
  - `mem_addr`, `mem_wdata` and `mem_wr` are muxed from `owner`'s fields.
  - At the end of the cycle, capture `mem_rdata` into `rdata_q` (also for writes; the value is then don't-care to the requester), set `prio = ~owner`, and go to RESP.
- RESP:
  - `ack[owner]` = 1 and `rdata[owner]` = `rdata_q`.
  - If the non-owner's req is high, set `owner = ~owner` and go to ACCESS (back-to-back service). Otherwise go to IDLE.
  - The owner's own req is ignored in RESP.
- Requester rule: in the cycle after its ack, the requester either deasserts req or presents a new request.
- Outside ACCESS: `mem_wr` = 0, `mem_addr` = 0, `mem_wdata` = 0. `rdata0/1` = 0 when the matching ack is low.
- Addresses pass through unmodified; `datamem` handles the byte lanes (addr..addr+3, MSB first).

## Timing
- Uncontended latency: req seen in IDLE at cycle N, ACCESS at N+1, ack at N+2. A write commits on the edge ending N+1.
- Contended: second requester gets ACCESS at N+3 and ack at N+4. Sustained throughput with both requesting is one access per 2 cycles, alternating.
- Reset values: state IDLE, `prio` = 0, `owner` = 0, `rdata_q` = 0, `err_q` = 0, all acks 0, `mem_wr` = 0.
- Reset asserted during ACCESS: the write is still driven in that cycle (`mem_wr` is combinational from state), but state returns to IDLE, no ack is issued, and the requester must reissue.
- A req dropped before its ack is a protocol violation; behaviour is undefined but no deadlock is allowed (FSM still reaches IDLE).

## Configuration
- `DMEM_ALIGN_CHECK_EN` defined:
  - In ACCESS, if `addr[owner][1:0]` != 0, force `mem_wr` = 0 and set `err_q` = 1.
  - `err[owner]` is high with the ack; `rdata` is still the captured word.
- Not defined: no alignment check, `err0`/`err1` ports absent, and misaligned accesses go to memory as-is.

## Structure
- Shared package `dmem_pkg`: `WORD_WIDTH` default, FSM state enum (`ST_IDLE`, `ST_ACCESS`, `ST_RESP`), requester index constants `REQ_CPU` = 0 and `REQ_AUX` = 1.
- One natural sub-module, `rr_pick2`: combinational 2-way round-robin winner select from (req0, req1, prio).
- Memory port mux and FSM stay in `datamem_arbiter`.

## Test plan
- **Reset:** assert `rst` 2 cycles with both req high -> no ack, `mem_wr` = 0, all outputs 0; first grant after release goes to requester 0.
- **Single write then read:** req0 write 0x00000010 / 0xDEADBEEF -> `mem_wr` = 1 for exactly 1 cycle and `ack0` at N+2. Then req0 read 0x10 -> `rdata0` = 0xDEADBEEF with `ack0`.
- **Contention:** req0 and req1 reads both asserted at the same cycle from reset -> `ack0` at N+2 and `ack1` at N+4; with both held continuously, acks alternate 0,1,0,1 every 2 cycles.
- **Write/read race:** req1 writes 0x20 = 0x12345678 while req0 reads 0x20 in the same cycle, `prio` = 1 -> req1 is served first and req0 returns 0x12345678.
- **Alignment (`DMEM_ALIGN_CHECK_EN`):** req0 write to 0x00000013 -> `mem_wr` stays 0, `err0` = 1 with `ack0`, and memory is unchanged on readback.
- **Mid-access reset:** `rst` during ACCESS of a req1 read -> no `ack1`, state IDLE next cycle; reissued req1 completes normally.
